// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// Holds the default data width / depth and the matching address and data
// typedefs used by the decoder and pipeline stages around regfile_mp.
package regfile_mp_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0] addr_t;
  typedef logic [DW_DEF-1:0] data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-register scoreboard for regfile_mp.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   lock_en    qualified lock request (already range/zero-reg filtered)
//   lock_addr  register to mark pending
//   clr_vec    one-hot-per-register clear mask from accepted writes
//   busy_vec   registered pending flags, bit i = register i
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  input  logic [DEPTH-1:0] clr_vec,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    set_vec = '0;
    if (lock_en) set_vec[lock_addr] = 1'b1;
    // Set is applied after clear so a same-cycle lock keeps the bit pending.
    busy_nxt = (busy_vec & ~clr_vec) | set_vec;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and a
// pending-register scoreboard.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   we         per-write-port enable
//   waddr      packed write addresses, port k at [k*AW +: AW]
//   wdata      packed write data, port k at [k*DW +: DW]
//   raddr      packed read addresses, port j at [j*AW +: AW]
//   rdata      packed combinational read data
//   rbusy      per-read-port pending flag of the addressed register
//   lock_en    mark lock_addr pending at the next edge
//   lock_addr  register to mark pending
//   busy_vec   registered scoreboard, bit i = register i pending
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    we,
  input  logic [NUM_WR*AW-1:0] waddr,
  input  logic [NUM_WR*DW-1:0] wdata,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD*DW-1:0] rdata,
  output logic [NUM_RD-1:0]    rbusy,
  input  logic                 lock_en,
  input  logic [AW-1:0]        lock_addr,
  output logic [DEPTH-1:0]     busy_vec
);

  // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (DEPTH >= (1 << AW)) || (32'(a) < DEPTH);
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic [DW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wa  [NUM_WR];
  logic [DW-1:0]     wd  [NUM_WR];
  logic [AW-1:0]     ra  [NUM_RD];
  logic [NUM_WR-1:0] we_ok;
  logic [DEPTH-1:0]  clr_vec;
  logic              lock_ok;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign wa[k] = waddr[k*AW +: AW];
    assign wd[k] = wdata[k*DW +: DW];
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_unpack
    assign ra[j] = raddr[j*AW +: AW];
  end

  // Accepted writes: enabled, not in reset, in range and not the zero register.
  always_comb begin
    we_ok   = '0;
    clr_vec = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      we_ok[k] = we[k] && !rst && addr_ok(wa[k]) && !is_zero(wa[k]);
      if (we_ok[k]) clr_vec[wa[k]] = 1'b1;
    end
  end

  assign lock_ok = lock_en && !rst && addr_ok(lock_addr) && !is_zero(lock_addr);

  // Later write ports are applied last, so port 1 wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we_ok[k]) mem[wa[k]] <= wd[k];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (addr_ok(ra[j]) && !is_zero(ra[j])) begin
        rdata[j*DW +: DW] = mem[ra[j]];
        rbusy[j]          = busy_vec[ra[j]];
      end
      // we_ok already excludes reset, discarded and out-of-range writes.
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (we_ok[k] && (wa[k] == ra[j])) begin
            rdata[j*DW +: DW] = wd[k];
            rbusy[j]          = 1'b0;
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .lock_en   (lock_ok),
    .lock_addr (lock_addr),
    .clr_vec   (clr_vec),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with two write ports, bypass,
// zero register and a non-power-of-two depth; one instance without bypass.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: DEPTH=12 (AW=4), NUM_WR=2, BYPASS=1, ZERO_REG=1
  logic [1:0]  we_a;
  logic [7:0]  waddr_a;
  logic [63:0] wdata_a;
  logic [7:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [1:0]  rbusy_a;
  logic        lock_en_a;
  logic [3:0]  lock_addr_a;
  logic [11:0] busy_a;

  // Instance B: DEPTH=32 (AW=5), NUM_WR=1, BYPASS=0, ZERO_REG=1
  logic [0:0]  we_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [9:0]  raddr_b;
  logic [63:0] rdata_b;
  logic [1:0]  rbusy_b;
  logic        lock_en_b;
  logic [4:0]  lock_addr_b;
  logic [31:0] busy_b;

  regfile_mp #(.DW(32), .DEPTH(12), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .lock_en(lock_en_a), .lock_addr(lock_addr_a), .busy_vec(busy_a)
  );

  regfile_mp #(.DW(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .lock_en(lock_en_b), .lock_addr(lock_addr_b), .busy_vec(busy_b)
  );

  typedef struct {
    logic [1:0]  we;
    logic [3:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        lk;
    logic [3:0]  la;
    logic [3:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;     // expected rbusy, bit 0 = read port 0
    logic [11:0] ebusy;  // expected busy_vec before this vector's edge
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] we, input logic [3:0] wa0, input logic [31:0] wd0,
                     input logic [3:0] wa1, input logic [31:0] wd1,
                     input logic lk, input logic [3:0] la,
                     input logic [3:0] ra0, input logic [3:0] ra1,
                     input logic [31:0] e0, input logic [31:0] e1,
                     input logic [1:0] eb, input logic [11:0] ebusy);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.lk = lk; v.la = la; v.ra0 = ra0; v.ra1 = ra1;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ebusy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    we_a = '0; waddr_a = '0; wdata_a = '0; raddr_a = '0; lock_en_a = 1'b0; lock_addr_a = '0;
    we_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0; lock_en_b = 1'b0; lock_addr_b = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    //   we     wa0 wd0           wa1 wd1    lk la  ra0 ra1 e0            e1            eb     ebusy
    add(2'b01, 5,  32'hDEADBEEF, 0,  0,     0, 0,  5,  0,  32'hDEADBEEF, 0,            2'b00, 12'h000);
    add(2'b00, 0,  0,            0,  0,     1, 3,  5,  3,  32'hDEADBEEF, 0,            2'b00, 12'h000);
    add(2'b00, 0,  0,            0,  0,     0, 0,  3,  5,  0,            32'hDEADBEEF, 2'b01, 12'h008);
    add(2'b01, 3,  32'h33,       0,  0,     1, 3,  3,  3,  32'h33,       32'h33,       2'b00, 12'h008);
    add(2'b11, 7,  32'h11,       7,  32'h22,0, 0,  3,  7,  32'h33,       32'h22,       2'b01, 12'h008);
    add(2'b01, 0,  32'hFFFF,     0,  0,     1, 0,  7,  0,  32'h22,       0,            2'b00, 12'h008);
    add(2'b10, 0,  0,            3,  32'h44,0, 0,  0,  3,  0,            32'h44,       2'b00, 12'h008);
    add(2'b01, 13, 32'hBAD,      0,  0,     1, 14, 3,  12, 32'h44,       0,            2'b00, 12'h000);
    add(2'b00, 0,  0,            0,  0,     1, 9,  13, 14, 0,            0,            2'b00, 12'h000);
    add(2'b11, 11, 32'hAB,       10, 32'hCD,0, 0,  9,  11, 0,            32'hAB,       2'b01, 12'h200);
    add(2'b00, 0,  0,            0,  0,     0, 0,  10, 11, 32'hCD,       32'hAB,       2'b00, 12'h200);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Post-reset sweep of every address, including the out-of-range ones.
    for (int a = 0; a < 16; a++) begin
      raddr_a = {4'(a), 4'(15 - a)};
      @(negedge clk);
      chk($sformatf("reset rd a=%0d", a), rdata_a, 64'h0);
      chk($sformatf("reset rbusy a=%0d", a), {62'h0, rbusy_a}, 64'h0);
    end
    chk("reset busy_a", {52'h0, busy_a}, 64'h0);
    chk("reset busy_b", {32'h0, busy_b}, 64'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      we_a        = vecs[i].we;
      waddr_a     = {vecs[i].wa1, vecs[i].wa0};
      wdata_a     = {vecs[i].wd1, vecs[i].wd0};
      lock_en_a   = vecs[i].lk;
      lock_addr_a = vecs[i].la;
      raddr_a     = {vecs[i].ra1, vecs[i].ra0};
      @(negedge clk);
      chk($sformatf("v%0d rdata0", i), {32'h0, rdata_a[31:0]},  {32'h0, vecs[i].e0});
      chk($sformatf("v%0d rdata1", i), {32'h0, rdata_a[63:32]}, {32'h0, vecs[i].e1});
      chk($sformatf("v%0d rbusy", i),  {62'h0, rbusy_a},        {62'h0, vecs[i].eb});
      chk($sformatf("v%0d busy_vec", i), {52'h0, busy_a},       {52'h0, vecs[i].ebusy});
      @(posedge clk); #1;
    end

    // One-cycle reset with reg9 pending and a write+lock presented during reset.
    rst = 1'b1;
    we_a = 2'b01; waddr_a = {4'd0, 4'd2}; wdata_a = {32'h0, 32'h55};
    lock_en_a = 1'b1; lock_addr_a = 4'd2; raddr_a = {4'd9, 4'd2};
    @(negedge clk);
    chk("rst bypass suppressed", {32'h0, rdata_a[31:0]}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    raddr_a = {4'd2, 4'd9};
    @(negedge clk);
    chk("post-rst busy_vec", {52'h0, busy_a}, 64'h0);
    chk("post-rst reg9", {32'h0, rdata_a[31:0]}, 64'h0);
    chk("post-rst reg2", {32'h0, rdata_a[63:32]}, 64'h0);
    chk("post-rst rbusy", {62'h0, rbusy_a}, 64'h0);
    @(posedge clk); #1;
    raddr_a = {4'd10, 4'd11};
    @(negedge clk);
    chk("post-rst reg10/11", rdata_a, 64'h0);
    @(posedge clk); #1;

    // No-bypass instance: write visible only after the edge.
    we_b = 1'b1; waddr_b = 5'd5; wdata_b = 32'hDEADBEEF; raddr_b = {5'd0, 5'd5};
    @(negedge clk);
    chk("nobyp same-cycle rd", {32'h0, rdata_b[31:0]}, 64'h0);
    @(posedge clk); #1;
    we_b = 1'b0;
    @(negedge clk);
    chk("nobyp next-cycle rd", {32'h0, rdata_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
    @(posedge clk); #1;

    // Lock reg4, then write it: rbusy stays up until the edge without bypass.
    lock_en_b = 1'b1; lock_addr_b = 5'd4;
    @(posedge clk); #1;
    lock_en_b = 1'b0;
    we_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'h77; raddr_b = {5'd5, 5'd4};
    @(negedge clk);
    chk("nobyp lock busy_vec", {32'h0, busy_b}, 64'h10);
    chk("nobyp lock rbusy", {62'h0, rbusy_b}, 64'h1);
    chk("nobyp lock old rd", {32'h0, rdata_b[31:0]}, 64'h0);
    @(posedge clk); #1;
    we_b = 1'b0;
    @(negedge clk);
    chk("nobyp clr busy_vec", {32'h0, busy_b}, 64'h0);
    chk("nobyp clr rbusy", {62'h0, rbusy_b}, 64'h0);
    chk("nobyp new rd", rdata_b, 64'hDEAD_BEEF_0000_0077);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DW, 32, data width in bits.
REQ-002 Parameter DEPTH, 32, number of registers, 2..256; AW = clog2(DEPTH) is a derived local constant.
REQ-003 Parameter NUM_RD, 2, number of read ports, 1..4.
REQ-004 Parameter NUM_WR, 1, number of write ports, 1..2.
REQ-005 Parameter BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding.
REQ-006 Parameter ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy.
REQ-007 The interface SHALL be: one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-008 clk  in  1  rising-edge clock for all state.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 we  in  NUM_WR  per-port write enable.
REQ-011 waddr  in  NUM_WR*AW  packed write addresses, port k at bits [k*AW +: AW].
REQ-012 wdata  in  NUM_WR*DW  packed write data.
REQ-013 raddr  in  NUM_RD*AW  packed read addresses.
REQ-014 rdata  out  NUM_RD*DW  packed read data, combinational.
REQ-015 rbusy  out  NUM_RD  per-read-port pending flag for the addressed register.
REQ-016 lock_en  in  1  marks lock_addr as pending (producer issued).
REQ-017 lock_addr  in  AW  register to mark pending.
REQ-018 busy_vec  out  DEPTH  registered scoreboard, bit i = register i pending.

Function
REQ-019 Write: at the rising clk edge with we[k]=1 and rst=0, reg[waddr_k] SHALL take wdata_k; one-cycle write latency.
REQ-020 Two write ports hitting the same address in one cycle: port 1 data SHALL win.
REQ-021 ZERO_REG=1: writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0.
REQ-022 Addresses >= DEPTH: writes SHALL be ignored, locks SHALL be ignored, and reads SHALL return 0 with rbusy=0.
REQ-023 Read: rdata_j SHALL equal reg[raddr_j] combinationally; zero read latency.
REQ-024 BYPASS=1: when a write enable is asserted this cycle to raddr_j (excluding discarded writes), rdata_j SHALL return that write's data, with the highest matching port index winning.
REQ-025 BYPASS=0: rdata_j SHALL show the old value until after the edge.
REQ-026 Scoreboard: at the edge, lock_en=1 SHALL set busy_vec[lock_addr], and an accepted write SHALL clear busy_vec[waddr].
REQ-027 Lock and write to the same address in one cycle: the busy bit SHALL end set, because lock wins.
REQ-028 ZERO_REG=1: busy_vec[0] SHALL be constant 0.
REQ-029 rbusy_j SHALL equal busy_vec[raddr_j], cleared when BYPASS=1 and an accepted write to raddr_j occurs this cycle.
REQ-030 Independent addresses SHALL update in the same cycle without interaction.

Reset
REQ-031 rst=1 at an edge SHALL clear all registers and busy_vec to 0, with a single-cycle reset.
REQ-032 Writes and locks presented during rst SHALL be ignored.
REQ-033 Bypass SHALL be suppressed while rst=1.
REQ-034 After reset, rdata SHALL be 0 for all addresses, and rbusy and busy_vec SHALL be 0.
REQ-035 Reset asserted mid-sequence, such as a pending lock, SHALL leave no residual busy bit.
REQ-036 Initial blocks SHALL NOT be relied on for state.

Structure
REQ-037 A shared package SHALL hold the default DW/DEPTH constants and the addr_t/data_t typedefs, for use by the decoder and pipeline.
REQ-038 The scoreboard SHALL be one sub-module, regfile_scoreboard, with inputs lock, write-clear and rst and outputs busy_vec.
REQ-039 Storage and bypass muxing SHALL remain in the top module.

Verification
REQ-040 Reset then read all addresses: rdata=0, busy_vec=0.
REQ-041 Write reg5=0xDEADBEEF, BYPASS=1, read port 0 addr 5 same cycle: rdata0=0xDEADBEEF immediately.
REQ-042 The same write with BYPASS=0: old value 0 same cycle, 0xDEADBEEF the next cycle.
REQ-043 NUM_WR=2, both ports write reg7 (0x11, 0x22): reg7=0x22 next cycle.
REQ-044 Write reg0=0xFFFF with ZERO_REG=1, then lock addr 0: rdata=0, busy_vec[0]=0.
REQ-045 Lock reg3 at cycle N: busy_vec[3]=1 at N+1, and rbusy=1 for raddr=3.
REQ-046 Write reg3 at N+2 with lock reg3 at N+2: busy_vec[3] stays 1.
REQ-047 Lock reg9, then assert rst one cycle: busy_vec=0 and reg9 reads 0.
